updown_counter: RTL

//  Parametrised bidirectional counter over a programmable range [MIN,MAX], step STEP.

---
 rtl/updown_counter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/updown_counter.sv
// ----------------------------------------------------------------------------
// updown_counter
//
// Bidirectional counter over the programmable range [MIN, MAX] that moves by
// STEP on each enabled cycle. At a boundary it either wraps or saturates
// (SATURATE). Supports a synchronous load that clamps into range and gives
// single-cycle overflow/underflow pulses. All outputs are registered.
//
// Optional feature (macro COUNTER_SNAPSHOT_EN, normally set in config.vh):
//   adds snap_i / snap_count_o. When snap_i is high, the count from before
//   the edge is captured into snap_count_o.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   clr_i         synchronous clear, same result as reset
//   en_i          count enable
//   dir_i         1 = up (+STEP), 0 = down (-STEP)
//   load_i        synchronous load of load_val_i (clamped into [MIN, MAX])
//   load_val_i    load value
//   snap_i        capture strobe           (COUNTER_SNAPSHOT_EN only)
//   snap_count_o  captured count           (COUNTER_SNAPSHOT_EN only)
//   count_o       current count
//   overflow_o    1-cycle pulse, an up-step crossed MAX
//   underflow_o   1-cycle pulse, a down-step crossed MIN
//   at_max_o      count_o == MAX
//   at_min_o      count_o == MIN
// ----------------------------------------------------------------------------
module updown_counter #(
    parameter int unsigned     NBITS    = 8,
    parameter longint unsigned MIN      = 0,
    parameter longint unsigned MAX      = (64'd1 << NBITS) - 64'd1,
    parameter longint unsigned STEP     = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [NBITS-1:0] load_val_i,
`ifdef COUNTER_SNAPSHOT_EN
    input  logic             snap_i,
    output logic [NBITS-1:0] snap_count_o,
`endif
    output logic [NBITS-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    // Two extra bits: one for headroom above MAX and one for the sign below
    // zero, so count +/- STEP can never alias back into range.
    localparam int unsigned W = NBITS + 2;

    localparam logic signed [W-1:0] MinS   = W'(MIN);
    localparam logic signed [W-1:0] MaxS   = W'(MAX);
    localparam logic signed [W-1:0] StepS  = W'(STEP);
    localparam logic signed [W-1:0] RangeS = W'(MAX - MIN + 64'd1);
    localparam logic [NBITS-1:0]    MinV   = NBITS'(MIN);
    localparam logic [NBITS-1:0]    MaxV   = NBITS'(MAX);

    // Reject illegal configurations at elaboration.
    if (NBITS < 1 || NBITS > 32) begin : g_bad_nbits
        $fatal(1, "updown_counter: NBITS must be in 1..32");
    end else if (MIN >= MAX) begin : g_bad_range
        $fatal(1, "updown_counter: MIN must be below MAX");
    end else if (MAX >= (64'd1 << NBITS)) begin : g_bad_max
        $fatal(1, "updown_counter: MAX does not fit in NBITS");
    end else if (STEP == 0) begin : g_bad_step_zero
        $fatal(1, "updown_counter: STEP must be nonzero");
    end else if (STEP > MAX - MIN) begin : g_bad_step_big
        $fatal(1, "updown_counter: STEP exceeds MAX-MIN");
    end

    logic [NBITS-1:0] count_d, count_q;
    logic             overflow_d, overflow_q;
    logic             underflow_d, underflow_q;
    logic             at_max_d, at_max_q;
    logic             at_min_d, at_min_q;

    logic signed [W-1:0] cur_s, up_s, dn_s, ld_s, up_wrap_s, dn_wrap_s;

    always_comb begin
        cur_s     = {2'b00, count_q};
        ld_s      = {2'b00, load_val_i};
        up_s      = cur_s + StepS;
        dn_s      = cur_s - StepS;
        // Wrapping by one full range length equals MIN + (next - MAX - 1)
        // going up and MAX - (MIN - next - 1) going down.
        up_wrap_s = up_s - RangeS;
        dn_wrap_s = dn_s + RangeS;

        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (clr_i) begin
            count_d = MinV;
        end else if (load_i) begin
            if (ld_s < MinS) begin
                count_d = MinV;
            end else if (ld_s > MaxS) begin
                count_d = MaxV;
            end else begin
                count_d = load_val_i;
            end
        end else if (en_i) begin
            if (dir_i) begin
                if (up_s > MaxS) begin
                    overflow_d = 1'b1;
                    count_d    = SATURATE ? MaxV : up_wrap_s[NBITS-1:0];
                end else begin
                    count_d = up_s[NBITS-1:0];
                end
            end else begin
                if (dn_s < MinS) begin
                    underflow_d = 1'b1;
                    count_d     = SATURATE ? MinV : dn_wrap_s[NBITS-1:0];
                end else begin
                    count_d = dn_s[NBITS-1:0];
                end
            end
        end

        at_max_d = (count_d == MaxV);
        at_min_d = (count_d == MinV);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= MinV;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            at_max_q    <= 1'b0;
            at_min_q    <= 1'b1;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            at_max_q    <= at_max_d;
            at_min_q    <= at_min_d;
        end
    end

    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign at_max_o    = at_max_q;
    assign at_min_o    = at_min_q;

`ifdef COUNTER_SNAPSHOT_EN
    logic [NBITS-1:0] snap_count_d, snap_count_q;

    // Captures count_q, not count_d, so a snap in a load cycle keeps the old value.
    always_comb begin
        snap_count_d = snap_count_q;
        if (clr_i) begin
            snap_count_d = MinV;
        end else if (snap_i) begin
            snap_count_d = count_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_count_q <= MinV;
        end else begin
            snap_count_q <= snap_count_d;
        end
    end

    assign snap_count_o = snap_count_q;
`endif

endmodule
